fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 157 +++++++++++++++
 tb/tb_fetch_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with a 2-entry instruction buffer
//
// Issues word-aligned fetches to instruction memory, queues returned words in a
// 2-entry FIFO of {instr, instr_pc} and hands them to decode.
// A redirect flushes the FIFO and retargets the fetch PC. A request already
// presented to memory is never withdrawn; its late response is discarded.
//
// Ports
//   clock, reset_n             : single clock, asynchronous active-low reset
//   imem_req/imem_addr         : fetch request and word address to memory
//   imem_ready/imem_data       : memory completion and returned instruction word
//   stall                      : decode cannot accept the head instruction
//   redirect_valid/redirect_pc : branch/jump retarget pulse and target
//   instr_valid/instr/instr_pc : head of the instruction buffer
//   pc_out                     : address of the next fetch to be issued
//   fetch_count                : instructions consumed downstream (mod 2^16)
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_out,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic        req_pending;   // request was presented last cycle and not completed
    logic [31:0] req_addr;      // address that pending request was presented with
    logic [15:0] fetch_cnt_q;

    logic        push;
    logic        pop;
    logic        flush;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        // A pending request must keep its original address even if pc moved.
        imem_addr = req_pending ? req_addr : pc_q;
        pc_nxt    = pc_q;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                // Only request when the response has a free slot to land in,
                // or when a request is already committed to memory.
                imem_req = (count < 2'd2) || req_pending;
                if (redirect_valid) begin
                    flush  = 1'b1;
                    pc_nxt = redirect_target;
                    if (imem_req && !imem_ready) begin
                        state_nxt = DISCARD;
                    end
                end else begin
                    pop = (count != 2'd0) && !stall;
                    if (imem_req && imem_ready) begin
                        push   = 1'b1;
                        pc_nxt = pc_q + 32'd4;
                    end
                end
            end
            DISCARD: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    flush  = 1'b1;
                    pc_nxt = redirect_target;
                end
                if (imem_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc_q        <= RESET_ADDR;
            req_pending <= 1'b0;
            req_addr    <= RESET_ADDR;
            fetch_cnt_q <= 16'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= 32'd0;
                buf_pc[i]    <= 32'd0;
            end
        end else begin
            state       <= state_nxt;
            pc_q        <= pc_nxt;
            req_pending <= imem_req && !imem_ready;
            req_addr    <= imem_addr;
            if (flush) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    buf_instr[wr_ptr] <= imem_data;
                    buf_pc[wr_ptr]    <= pc_q;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr      <= ~rd_ptr;
                    fetch_cnt_q <= fetch_cnt_q + 16'd1;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? buf_instr[rd_ptr] : 32'd0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr] : 32'd0;
    assign pc_out      = pc_q;
    assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized self-checking bench for fetch_controller
module tb_fetch_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_out;
    logic [15:0] fetch_count;

    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_data = word_of(imem_addr);

    fetch_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_out         (pc_out),
        .fetch_count    (fetch_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 = idle, 1 = fetching, 2 = dropping a stale response.
    int          mst;
    logic [31:0] mq[$];
    logic [31:0] mpc;
    logic [31:0] mraddr;
    bit          mpend;
    logic [15:0] mcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mst    = 0;
        mq.delete();
        mpc    = 32'd0;
        mraddr = 32'd0;
        mpend  = 1'b0;
        mcnt   = 16'd0;
    endtask

    task automatic cycle(input bit rdy, input bit st, input bit rv, input logic [31:0] rp);
        bit          ereq;
        logic [31:0] eaddr;
        @(negedge clock);
        imem_ready     = rdy;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
        ereq  = (mst == 1 && (mq.size() < 2 || mpend)) || mst == 2;
        eaddr = mpend ? mraddr : mpc;
        chk("imem_req", 32'(imem_req), 32'(ereq));
        if (ereq) chk("imem_addr", imem_addr, eaddr);
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("instr_pc", instr_pc, mq[0]);
            chk("instr", instr, word_of(mq[0]));
        end
        chk("pc_out", pc_out, mpc);
        chk("fetch_count", 32'(fetch_count), 32'(mcnt));
        if (mst == 0) begin
            mst = 1;
        end else if (rv) begin
            mq.delete();
            mpc = rp & 32'hFFFF_FFFC;
            if (ereq && !rdy) begin
                mst = 2; mpend = 1'b1; mraddr = eaddr;
            end else begin
                mst = 1; mpend = 1'b0;
            end
        end else if (mst == 2) begin
            if (rdy) begin
                mst = 1; mpend = 1'b0;
            end
        end else begin
            if (mq.size() != 0 && !st) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (ereq && rdy) begin
                mq.push_back(mpc);
                mpc += 32'd4;
            end
            mpend  = ereq && !rdy;
            mraddr = eaddr;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n        = 1'b0;
        imem_ready     = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_fetch_count", 32'(fetch_count), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        chk("rst_hold_req", 32'(imem_req), 32'd0);
        chk("rst_hold_pc", pc_out, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Zero-wait memory, no stall: one instruction per cycle in order.
        cycle(1, 0, 0, 0);
        chk("idle_req", 32'(imem_req), 32'd0);
        cycle(1, 0, 0, 0);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        for (int k = 2; k < 10; k++) begin
            cycle(1, 0, 0, 0);
            chk("seq_pc", instr_pc, 32'((k - 2) * 4));
            chk("seq_cnt", 32'(fetch_count), 32'(k - 2));
        end

        // Stall fills the buffer and stops requests; release drains in order.
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_pc", instr_pc, 32'd32);
        chk("stall_cnt", 32'(fetch_count), 32'd8);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0);
            chk("drain_pc", instr_pc, 32'(32 + 4 * i));
        end

        // Redirect during a slow fetch at 0x8.
        do_reset();
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        chk("slow_addr", imem_addr, 32'h8);
        cycle(0, 1, 1, 32'h100);
        cycle(0, 0, 0, 0);
        chk("disc_req", 32'(imem_req), 32'd1);
        chk("disc_addr", imem_addr, 32'h8);
        chk("disc_valid", 32'(instr_valid), 32'd0);
        chk("disc_pc_out", pc_out, 32'h100);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("retgt_addr", imem_addr, 32'h100);
        chk("retgt_valid", 32'(instr_valid), 32'd0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("retgt_wait_valid", 32'(instr_valid), 32'd0);
        cycle(0, 1, 0, 0);
        chk("retgt_head_pc", instr_pc, 32'h100);
        chk("retgt_head", instr, word_of(32'h100));

        // Misaligned redirect near the top of memory, then address wrap.
        cycle(1, 1, 1, 32'hFFFF_FFFE);
        cycle(1, 1, 0, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_valid", 32'(instr_valid), 32'd0);
        cycle(1, 1, 0, 0);
        chk("wrap_pc_out", pc_out, 32'd0);
        chk("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);

        // Redirect together with stall on a full buffer.
        cycle(1, 1, 0, 0);
        chk("full_req", 32'(imem_req), 32'd0);
        cycle(1, 1, 1, 32'h200);
        cycle(0, 1, 0, 0);
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_cnt", 32'(fetch_count), 32'd1);
        chk("flush_addr", imem_addr, 32'h200);

        // Reset with a request outstanding; a late response must be ignored.
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("restart_addr", imem_addr, 32'd0);
        chk("restart_req", 32'(imem_req), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 4) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 60,
                      $urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 6,
                      $urandom());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
